// File: rtl/data_mem_io_pkg.sv
// Shared address map and register bit positions for the CPU memory-stage slave.
// Imported by the top level and the timer block.
package data_mem_io_pkg;

  localparam int IO_SEL_BIT = 7;

  localparam logic [7:0] ADDR_OUT0   = 8'h80;
  localparam logic [7:0] ADDR_OUT1   = 8'h84;
  localparam logic [7:0] ADDR_OUT2   = 8'h88;
  localparam logic [7:0] ADDR_IN0    = 8'hC0;
  localparam logic [7:0] ADDR_IN1    = 8'hC4;
  localparam logic [7:0] ADDR_TCOUNT = 8'hD0;
  localparam logic [7:0] ADDR_TCMP   = 8'hD4;
  localparam logic [7:0] ADDR_TCTRL  = 8'hD8;
  localparam logic [7:0] ADDR_TSTAT  = 8'hDC;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_IRQ_BIT   = 1;
  localparam int STAT_MATCH_BIT = 0;

  typedef enum logic [1:0] {
    TREG_COUNT = 2'd0,
    TREG_CMP   = 2'd1,
    TREG_CTRL  = 2'd2,
    TREG_STAT  = 2'd3
  } timer_reg_e;

endpackage

// File: rtl/data_mem_io_timer.sv
// Free-running compare timer with a sticky match flag and a gated interrupt.
// Register select comes straight from addr[3:2] of the 0xD0..0xDC window.
module io_timer
  import data_mem_io_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_we,
  input  timer_reg_e  i_sel,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [1:0]  r_ctrl;
  logic        r_match;
  logic        w_en;
  logic        w_set;
  logic        w_clr;

  assign w_en  = r_ctrl[CTRL_EN_BIT];
  assign w_set = w_en && (r_count == r_compare);
  assign w_clr = i_we && (i_sel == TREG_STAT) && i_wdata[STAT_MATCH_BIT];

  // A CPU write to the count wins over the increment; a match wins over a clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_compare <= '0;
      r_ctrl    <= '0;
      r_match   <= 1'b0;
    end else begin
      if (i_we && (i_sel == TREG_COUNT))
        r_count <= i_wdata;
      else if (w_en)
        r_count <= r_count + 32'd1;
      if (i_we && (i_sel == TREG_CMP))
        r_compare <= i_wdata;
      if (i_we && (i_sel == TREG_CTRL))
        r_ctrl <= i_wdata[1:0];
      r_match <= w_set | (r_match & ~w_clr);
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_sel)
      TREG_COUNT: o_rdata = r_count;
      TREG_CMP:   o_rdata = r_compare;
      TREG_CTRL:  o_rdata = {30'd0, r_ctrl};
      TREG_STAT:  o_rdata = {31'd0, r_match};
      default:    o_rdata = '0;
    endcase
  end

  assign o_irq = r_match & r_ctrl[CTRL_IRQ_BIT];

endmodule

// File: rtl/data_mem_io.sv
// Memory-stage slave: word RAM below 0x80, synchronized inputs, output ports and
// the compare timer above it. Loads are combinational; stores commit on the edge.
module data_mem_io
  import data_mem_io_pkg::*;
#(
  parameter int RAM_WORDS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wmem,
  output logic [31:0] rdata,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic        timer_irq
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [AW-1:0] IDX_MASK = AW'(RAM_WORDS - 1);

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_sync0 [SYNC_STAGES];
  logic [31:0]   r_sync1 [SYNC_STAGES];
  logic [31:0]   r_out0;
  logic [31:0]   r_out1;
  logic [31:0]   r_out2;
  logic          w_io_sel;
  logic [7:0]    w_io_off;
  logic [AW-1:0] w_ram_idx;
  logic          w_tmr_hit;
  logic [31:0]   w_tmr_rdata;
  logic [31:0]   w_io_rdata;
  logic          w_unused;

  assign w_io_sel  = addr[IO_SEL_BIT];
  assign w_io_off  = {addr[7:2], 2'b00};
  assign w_ram_idx = addr[2 +: AW] & IDX_MASK;
  assign w_tmr_hit = w_io_sel && (addr[7:4] == ADDR_TCOUNT[7:4]);
  assign w_unused  = ^{addr[31:8], addr[6:2], addr[1:0]};

  // No reset here so the array stays a plain memory; reset only blocks the store.
  always_ff @(posedge clock) begin
    if (wmem && !w_io_sel && !reset)
      r_ram[w_ram_idx] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync0[i] <= '0;
        r_sync1[i] <= '0;
      end
    end else begin
      r_sync0[0] <= in_port0;
      r_sync1[0] <= in_port1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync0[i] <= r_sync0[i-1];
        r_sync1[i] <= r_sync1[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out0 <= '0;
      r_out1 <= '0;
      r_out2 <= '0;
    end else if (wmem) begin
      if (w_io_off == ADDR_OUT0) r_out0 <= wdata;
      if (w_io_off == ADDR_OUT1) r_out1 <= wdata;
      if (w_io_off == ADDR_OUT2) r_out2 <= wdata;
    end
  end

  io_timer u_timer (
    .clock   (clock),
    .reset   (reset),
    .i_we    (wmem && w_tmr_hit),
    .i_sel   (timer_reg_e'(addr[3:2])),
    .i_wdata (wdata),
    .o_rdata (w_tmr_rdata),
    .o_irq   (timer_irq)
  );

  always_comb begin
    w_io_rdata = '0;
    case (w_io_off)
      ADDR_OUT0:   w_io_rdata = r_out0;
      ADDR_OUT1:   w_io_rdata = r_out1;
      ADDR_OUT2:   w_io_rdata = r_out2;
      ADDR_IN0:    w_io_rdata = r_sync0[SYNC_STAGES-1];
      ADDR_IN1:    w_io_rdata = r_sync1[SYNC_STAGES-1];
      ADDR_TCOUNT,
      ADDR_TCMP,
      ADDR_TCTRL,
      ADDR_TSTAT:  w_io_rdata = w_tmr_rdata;
      default:     w_io_rdata = '0;
    endcase
  end

  assign rdata     = w_io_sel ? w_io_rdata : r_ram[w_ram_idx];
  assign out_port0 = r_out0;
  assign out_port1 = r_out1;
  assign out_port2 = r_out2;

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io: every expected value below is hand-computed
// from the address map and the timer's cycle-by-cycle behaviour.
module tb_data_mem_io;

  logic        clock;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wmem;
  logic [31:0] rdata;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;

  data_mem_io #(.RAM_WORDS(32), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .wmem      (wmem),
    .rdata     (rdata),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2),
    .timer_irq (timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One store: drives the bus, takes one rising edge, returns 1ns after it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wmem  = 1'b1;
    @(posedge clock);
    #1;
    wmem  = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    checkOutput(tag, rdata, exp);
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    wmem     = 1'b0;
    addr     = '0;
    wdata    = '0;
    in_port0 = '0;
    in_port1 = '0;
    waitEdges(2);
    reset = 1'b0;

    readCheck("rst_out0", 32'h80, 32'h0);
    readCheck("rst_count", 32'hD0, 32'h0);
    readCheck("rst_status", 32'hDC, 32'h0);
    checkOutput("rst_irq", 32'(timer_irq), 32'h0);

    applyStimulus(32'h04, 32'hDEADBEEF);
    applyStimulus(32'h7C, 32'h12345678);
    readCheck("ram_04", 32'h04, 32'hDEADBEEF);
    readCheck("ram_7c", 32'h7C, 32'h12345678);
    readCheck("out1_untouched", 32'h84, 32'h0);
    readCheck("ram_alias_104", 32'h104, 32'hDEADBEEF);

    applyStimulus(32'h84, 32'h000000A5);
    checkOutput("out_port1", out_port1, 32'hA5);
    checkOutput("out_port0_idle", out_port0, 32'h0);
    readCheck("read_out1", 32'h84, 32'hA5);
    applyStimulus(32'hC0, 32'hFFFFFFFF);
    readCheck("in0_readonly", 32'hC0, 32'h0);
    applyStimulus(32'hE0, 32'h12345678);
    readCheck("unmapped_e0", 32'hE0, 32'h0);

    // Same-cycle read of a location being written returns the old value.
    addr  = 32'h88;
    wdata = 32'h7;
    wmem  = 1'b1;
    #1;
    checkOutput("rd_old_value", rdata, 32'h0);
    @(posedge clock);
    #1;
    wmem = 1'b0;
    checkOutput("rd_new_value", rdata, 32'h7);
    checkOutput("out_port2", out_port2, 32'h7);

    addr     = 32'hC0;
    in_port0 = 32'h55AA;
    waitEdges(1);
    checkOutput("sync_edge1", rdata, 32'h0);
    waitEdges(1);
    checkOutput("sync_edge2", rdata, 32'h55AA);
    in_port1 = 32'hCAFE0001;
    waitEdges(2);
    readCheck("sync_in1", 32'hC4, 32'hCAFE0001);

    // Compare match six edges after enabling from count=0, compare=5.
    applyStimulus(32'hD4, 32'd5);
    applyStimulus(32'hD0, 32'd0);
    applyStimulus(32'hD8, 32'h3);
    waitEdges(5);
    checkOutput("irq_before_match", 32'(timer_irq), 32'h0);
    readCheck("flag_before_match", 32'hDC, 32'h0);
    waitEdges(1);
    checkOutput("irq_at_match", 32'(timer_irq), 32'h1);
    readCheck("flag_at_match", 32'hDC, 32'h1);
    readCheck("count_at_match", 32'hD0, 32'd6);
    applyStimulus(32'hDC, 32'h1);
    readCheck("flag_cleared", 32'hDC, 32'h0);
    checkOutput("irq_cleared", 32'(timer_irq), 32'h0);
    waitEdges(3);
    checkOutput("irq_stays_low", 32'(timer_irq), 32'h0);

    applyStimulus(32'hD0, 32'hFFFFFFFF);
    readCheck("count_loaded_max", 32'hD0, 32'hFFFFFFFF);
    waitEdges(1);
    checkOutput("count_wrap", rdata, 32'h0);
    applyStimulus(32'hD0, 32'h100);
    readCheck("count_write_priority", 32'hD0, 32'h100);

    // Load 3, two increments to 5, then clear on the matching edge.
    applyStimulus(32'hD0, 32'd3);
    waitEdges(2);
    readCheck("flag_pre_setclr", 32'hDC, 32'h0);
    applyStimulus(32'hDC, 32'h1);
    readCheck("set_beats_clear", 32'hDC, 32'h1);
    checkOutput("irq_set_beats_clear", 32'(timer_irq), 32'h1);
    applyStimulus(32'hDC, 32'h0);
    readCheck("write0_no_clear", 32'hDC, 32'h1);
    readCheck("compare_read", 32'hD4, 32'd5);

    applyStimulus(32'hD8, 32'hFFFFFFFD);
    readCheck("ctrl_masked", 32'hD8, 32'h1);
    checkOutput("irq_gated_off", 32'(timer_irq), 32'h0);
    applyStimulus(32'hD8, 32'h0);
    readCheck("count_stopped", 32'hD0, 32'd9);
    waitEdges(3);
    readCheck("count_holds", 32'hD0, 32'd9);

    applyStimulus(32'hD8, 32'h1);
    waitEdges(2);
    readCheck("count_running", 32'hD0, 32'd11);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_count", rdata, 32'h0);
    checkOutput("async_rst_out1", out_port1, 32'h0);
    readCheck("async_rst_sync", 32'hC0, 32'h0);

    // Stores attempted while reset is held must not commit.
    applyStimulus(32'h80, 32'h77);
    applyStimulus(32'h04, 32'h11);
    reset = 1'b0;
    readCheck("no_io_write_in_rst", 32'h80, 32'h0);
    readCheck("no_ram_write_in_rst", 32'h04, 32'hDEADBEEF);
    readCheck("ram_survives_rst", 32'h7C, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
- Memory-stage slave of the five-stage pipelined CPU.
- Consumes the CPU's MEM-stage outputs: address (ALU result), store data and write enable.
- Returns load data to the CPU's memory-read input within the same cycle.
- Maps a word-addressed data RAM, synchronized input ports, registered output ports and a compare timer into one address space.

Parameters:
- RAM_WORDS, 32, number of 32-bit data RAM words; must be a power of two, at most 32.
- SYNC_STAGES, 2, flip-flop stages on each input port; at least 2.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  byte address from the CPU MEM stage; bits [1:0] ignored.
- wdata  input  32  store data from the CPU.
- wmem  input  1  store enable from the CPU.
- rdata  output  32  load data to the CPU; combinational from addr.
- in_port0  input  32  external input, asynchronous to clock.
- in_port1  input  32  external input, asynchronous to clock.
- out_port0  output  32  registered output port.
- out_port1  output  32  registered output port.
- out_port2  output  32  registered output port.
- timer_irq  output  1  timer match flag AND irq enable.

Behaviour:
- Decode uses addr[7:0] only; upper bits alias.
  - addr[7]=0 selects RAM; word index is addr[6:2] modulo RAM_WORDS.
  - addr[7]=1 selects IO.
- IO map:
  - 0x80, 0x84, 0x88: out_port0..2, read/write.
  - 0xC0, 0xC4: in_port0..1, synchronized, read-only.
  - 0xD0: timer count, read/write.
  - 0xD4: timer compare, read/write.
  - 0xD8: control; bit0 = enable, bit1 = irq enable; other bits read 0.
  - 0xDC: status; bit0 = match flag, write-1-to-clear.
- Unmapped IO addresses read 0; writes to them and to read-only ports are ignored.
- Reads are zero-latency combinational. A read in the same cycle as a write to the same location returns the old value.
- Writes commit at the rising edge when wmem=1.
- RAM contents are unaffected by reset (array must stay inferable as memory); undefined until written.
- Reset values: out_port0..2, count, compare, control, status and all synchronizer flops are 0; therefore rdata of every IO register reads 0 and timer_irq=0.
- Input sync: SYNC_STAGES-deep chain. A pin change is visible at 0xC0/0xC4 after SYNC_STAGES rising edges.
- Timer count:
  - When enable=1, count increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - When enable=0, count holds.
  - A CPU write to 0xD0 loads wdata and takes priority over the increment in that cycle.
- Match flag:
  - Set at the edge where enable=1 and the current count equals compare.
  - Sticky until cleared by writing a 1 to status bit0.
  - If set and clear occur in the same cycle, set wins.
  - Writing 0 to bit0 has no effect.
- timer_irq = status bit0 AND control bit1. Registered terms only; no combinational path from addr.
- Reset asserted mid-operation clears all registers immediately (asynchronous); no write commits on an edge while reset=1.
- wmem=1 with an X or undriven address is an illegal stimulus; the bench must not apply it.

Decomposition:
- Shared package data_mem_io_pkg:
  - IO address constants (OUT0..OUT2, IN0, IN1, TCOUNT, TCMP, TCTRL, TSTAT).
  - Control/status bit indices.
  - IO select bit index (7).
- One sub-module, io_timer:
  - Contains count, compare, control, status and the irq logic.
  - Interface: write strobe, 2-bit register select, wdata, rdata.
- Top level holds the RAM array, synchronizers, output ports and the read mux.

Test Plan:
- Reset then read: assert reset, release, read 0x80, 0xD0, 0xDC -> rdata=0 each; timer_irq=0.
- RAM: store 0xDEADBEEF at 0x04 and 0x12345678 at 0x7C; load 0x04 -> 0xDEADBEEF, 0x7C -> 0x12345678, 0x84 unaffected (reads 0).
- Output ports: store 0x000000A5 to 0x84 -> out_port1=0xA5 after that edge. Store to 0xC0 ignored (reads the synchronized pin). Read 0xE0 -> 0.
- Input sync: in_port0 changes 0 -> 0x55AA at cycle t -> rdata at 0xC0 is 0 through edge t+1 and 0x55AA after edge t+2.
- Timer match: write compare=5, count=0, control=0x3 -> flag and timer_irq rise 6 edges after the control write. Write 1 to 0xDC -> both clear; with count ≠ compare they stay 0.
- Timer edges:
  - Count=0xFFFFFFFF, enable=1 -> reads 0 after the next edge.
  - A write to 0xD0 during increment loads the written value.
  - Flag clear on the same cycle as a match -> flag remains 1.
  - Reset asserted mid-count -> count=0 asynchronously.
